// File: rtl/full_adder_if.sv
// -----------------------------------------------------------------------------
// full_adder_if
// Bundles the data, qualifier and status signals of one full_adder slice so a
// driver (master) and the slice (slave) can be connected as a single object.
//   master : drives a, b, cin, in_valid, cnt_clr; observes all results
//   slave  : consumes a, b, cin, in_valid, cnt_clr; drives all results
// Clock and reset are not part of the bundle; they stay scalar ports.
// -----------------------------------------------------------------------------
interface full_adder_if #(
  parameter int unsigned CNT_W = 8
);
  logic             a;
  logic             b;
  logic             cin;
  logic             in_valid;
  logic             cnt_clr;
  logic             cout;
  logic             s;
  logic             p;
  logic             g;
  logic             s_q;
  logic             cout_q;
  logic             valid_q;
  logic [CNT_W-1:0] carry_cnt;
  logic             cnt_sat;

  modport master (
    output a, b, cin, in_valid, cnt_clr,
    input  cout, s, p, g, s_q, cout_q, valid_q, carry_cnt, cnt_sat
  );

  modport slave (
    input  a, b, cin, in_valid, cnt_clr,
    output cout, s, p, g, s_q, cout_q, valid_q, carry_cnt, cnt_sat
  );
endinterface

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// One-bit full adder slice used as the repeating cell of a ripple-carry adder.
// Besides the latency-free sum/carry it offers propagate/generate terms for a
// lookahead network, a one-cycle registered copy of the result and a
// saturating counter of qualified carry-out events.
//
// Ports (positional order starts clk, rst, a, b, cin, cout, s so the cell can
// be dropped into a ripple chain positionally):
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset (registers only)
//   a, b       in   addend bits
//   cin        in   carry in
//   cout       out  carry out, combinational
//   s          out  sum, combinational
//   p          out  propagate (a ^ b), combinational
//   g          out  generate  (a & b), combinational
//   in_valid   in   qualifies the inputs for the registered path and counter
//   s_q        out  registered sum      (0 when REG_OUT = 0)
//   cout_q     out  registered carry    (0 when REG_OUT = 0)
//   valid_q    out  registered in_valid (0 when REG_OUT = 0)
//   cnt_clr    in   synchronous clear of the event counter
//   carry_cnt  out  saturating count of valid cycles with cout = 1
//   cnt_sat    out  high while carry_cnt is all ones
// -----------------------------------------------------------------------------
module full_adder #(
  parameter int unsigned CNT_W   = 8,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             cin,
  output logic             cout,
  output logic             s,
  output logic             p,
  output logic             g,
  input  logic             in_valid,
  output logic             s_q,
  output logic             cout_q,
  output logic             valid_q,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] carry_cnt,
  output logic             cnt_sat
);

  // ---------------------------------------------------------------------------
  // Combinational slice. Expressed through p/g so the carry is the classic
  // g | (cin & p) form a lookahead network expects.
  // ---------------------------------------------------------------------------
  logic w_p;
  logic w_g;
  logic w_s;
  logic w_cout;

  assign w_p    = a ^ b;
  assign w_g    = a & b;
  assign w_s    = w_p ^ cin;
  assign w_cout = w_g | (cin & w_p);

  assign p    = w_p;
  assign g    = w_g;
  assign s    = w_s;
  assign cout = w_cout;

  // ---------------------------------------------------------------------------
  // Registered result copy
  // ---------------------------------------------------------------------------
  generate
    if (REG_OUT) begin : g_reg_out
      logic r_s;
      logic r_cout;
      logic r_valid;

      // Data only updates on qualified cycles; the valid flag follows
      // in_valid every cycle so consumers see exactly one-cycle latency.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_s     <= 1'b0;
          r_cout  <= 1'b0;
          r_valid <= 1'b0;
        end else begin
          r_valid <= in_valid;
          if (in_valid) begin
            r_s    <= w_s;
            r_cout <= w_cout;
          end
        end
      end

      assign s_q     = r_s;
      assign cout_q  = r_cout;
      assign valid_q = r_valid;
    end else begin : g_no_reg_out
      assign s_q     = 1'b0;
      assign cout_q  = 1'b0;
      assign valid_q = 1'b0;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Saturating carry-out event counter
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_cnt_next;
  logic             w_cnt_full;

  assign w_cnt_full = &r_cnt;

  // Clear has priority over a same-cycle event; a full counter holds rather
  // than wrapping so statistics never under-report after overflow.
  always_comb begin
    r_cnt_next = r_cnt;
    if (cnt_clr) begin
      r_cnt_next = '0;
    end else if (in_valid && w_cout && !w_cnt_full) begin
      r_cnt_next = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt_next;
    end
  end

  assign carry_cnt = r_cnt;
  assign cnt_sat   = w_cnt_full;

endmodule

// File: tb/tb_full_adder.sv
module tb_full_adder;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (CNT_W=8, REG_OUT=1) through the interface
  full_adder_if #(.CNT_W(8)) fa_if ();

  full_adder #(.CNT_W(8), .REG_OUT(1'b1)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .a         (fa_if.a),
    .b         (fa_if.b),
    .cin       (fa_if.cin),
    .cout      (fa_if.cout),
    .s         (fa_if.s),
    .p         (fa_if.p),
    .g         (fa_if.g),
    .in_valid  (fa_if.in_valid),
    .s_q       (fa_if.s_q),
    .cout_q    (fa_if.cout_q),
    .valid_q   (fa_if.valid_q),
    .cnt_clr   (fa_if.cnt_clr),
    .carry_cnt (fa_if.carry_cnt),
    .cnt_sat   (fa_if.cnt_sat)
  );

  // Narrow-counter DUT for saturation, same inputs
  logic       d2_cout, d2_s, d2_p, d2_g, d2_sq, d2_coutq, d2_validq, d2_sat;
  logic [1:0] d2_cnt;
  full_adder #(.CNT_W(2), .REG_OUT(1'b1)) u_dut2 (
    .clk       (clk),
    .rst       (rst),
    .a         (fa_if.a),
    .b         (fa_if.b),
    .cin       (fa_if.cin),
    .cout      (d2_cout),
    .s         (d2_s),
    .p         (d2_p),
    .g         (d2_g),
    .in_valid  (fa_if.in_valid),
    .s_q       (d2_sq),
    .cout_q    (d2_coutq),
    .valid_q   (d2_validq),
    .cnt_clr   (fa_if.cnt_clr),
    .carry_cnt (d2_cnt),
    .cnt_sat   (d2_sat)
  );

  // REG_OUT=0 DUT, same inputs
  logic       d3_cout, d3_s, d3_p, d3_g, d3_sq, d3_coutq, d3_validq, d3_sat;
  logic [7:0] d3_cnt;
  full_adder #(.CNT_W(8), .REG_OUT(1'b0)) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .a         (fa_if.a),
    .b         (fa_if.b),
    .cin       (fa_if.cin),
    .cout      (d3_cout),
    .s         (d3_s),
    .p         (d3_p),
    .g         (d3_g),
    .in_valid  (fa_if.in_valid),
    .s_q       (d3_sq),
    .cout_q    (d3_coutq),
    .valid_q   (d3_validq),
    .cnt_clr   (fa_if.cnt_clr),
    .carry_cnt (d3_cnt),
    .cnt_sat   (d3_sat)
  );

  // 4-bit ripple chain
  logic [3:0] ra, rb, rs, rp, rg, rsq, rcq, rvq, rsat;
  logic [4:0] rc;
  logic       rcin;
  logic [7:0] rcnt [4];
  assign rc[0] = rcin;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ripple
      full_adder #(.CNT_W(8), .REG_OUT(1'b1)) u_slice (
        .clk       (clk),
        .rst       (rst),
        .a         (ra[gi]),
        .b         (rb[gi]),
        .cin       (rc[gi]),
        .cout      (rc[gi+1]),
        .s         (rs[gi]),
        .p         (rp[gi]),
        .g         (rg[gi]),
        .in_valid  (1'b0),
        .s_q       (rsq[gi]),
        .cout_q    (rcq[gi]),
        .valid_q   (rvq[gi]),
        .cnt_clr   (1'b0),
        .carry_cnt (rcnt[gi]),
        .cnt_sat   (rsat[gi])
      );
    end
  endgenerate

  // Counters
  int n_cmp;
  int n_fail;

  // Behavioural reference state
  logic m_sq, m_coutq, m_validq;
  int   m_cnt8, m_cnt2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Combinational outputs from the arithmetic sum of the three input bits
  task automatic check_comb(input string tag);
    int sum;
    int ab;
    sum = int'(fa_if.a) + int'(fa_if.b) + int'(fa_if.cin);
    ab  = int'(fa_if.a) + int'(fa_if.b);
    check({tag, ".s"},    32'(fa_if.s),    32'(sum % 2));
    check({tag, ".cout"}, 32'(fa_if.cout), 32'(sum / 2));
    check({tag, ".p"},    32'(fa_if.p),    32'(ab == 1));
    check({tag, ".g"},    32'(fa_if.g),    32'(ab == 2));
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".s_q"},      32'(fa_if.s_q),       32'(m_sq));
    check({tag, ".cout_q"},   32'(fa_if.cout_q),    32'(m_coutq));
    check({tag, ".valid_q"},  32'(fa_if.valid_q),   32'(m_validq));
    check({tag, ".cnt8"},     32'(fa_if.carry_cnt), 32'(m_cnt8));
    check({tag, ".sat8"},     32'(fa_if.cnt_sat),   32'(m_cnt8 == 255));
    check({tag, ".cnt2"},     32'(d2_cnt),          32'(m_cnt2));
    check({tag, ".sat2"},     32'(d2_sat),          32'(m_cnt2 == 3));
    check({tag, ".r0_s_q"},   32'({d3_sq, d3_coutq, d3_validq}), 32'(0));
    check({tag, ".r0_cnt"},   32'(d3_cnt),          32'(m_cnt8));
  endtask

  // One clock: model computes next state from the pre-edge inputs
  task automatic tick();
    int  sum;
    logic n_sq, n_cq, n_vq;
    int  n_c8, n_c2;
    sum  = int'(fa_if.a) + int'(fa_if.b) + int'(fa_if.cin);
    n_vq = fa_if.in_valid;
    n_sq = fa_if.in_valid ? logic'(sum % 2) : m_sq;
    n_cq = fa_if.in_valid ? logic'(sum / 2) : m_coutq;
    n_c8 = m_cnt8;
    n_c2 = m_cnt2;
    if (fa_if.cnt_clr) begin
      n_c8 = 0;
      n_c2 = 0;
    end else if (fa_if.in_valid && sum >= 2) begin
      if (n_c8 < 255) n_c8++;
      if (n_c2 < 3)   n_c2++;
    end
    @(posedge clk);
    #1;
    m_sq = n_sq; m_coutq = n_cq; m_validq = n_vq; m_cnt8 = n_c8; m_cnt2 = n_c2;
    $display("t=%0t a=%b b=%b cin=%b v=%b clr=%b | s_q=%b cout_q=%b valid_q=%b cnt=%0d cnt2=%0d sat2=%b",
             $time, fa_if.a, fa_if.b, fa_if.cin, fa_if.in_valid, fa_if.cnt_clr,
             fa_if.s_q, fa_if.cout_q, fa_if.valid_q, fa_if.carry_cnt, d2_cnt, d2_sat);
  endtask

  task automatic drive(input logic va, input logic vb, input logic vc,
                       input logic vv, input logic vclr);
    fa_if.a = va; fa_if.b = vb; fa_if.cin = vc;
    fa_if.in_valid = vv; fa_if.cnt_clr = vclr;
  endtask

  logic [7:0] s_tab;
  logic [7:0] c_tab;
  logic [4:0] rip_exp;

  initial begin
    n_cmp = 0; n_fail = 0;
    m_sq = 0; m_coutq = 0; m_validq = 0; m_cnt8 = 0; m_cnt2 = 0;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    ra = 4'h0; rb = 4'h0; rcin = 1'b0;
    s_tab = 8'b1001_0110;
    c_tab = 8'b1110_1000;

    // Reset state and truth table while in reset
    #3;
    check_regs("reset");
    for (int i = 0; i < 8; i++) begin
      drive(logic'(i >> 2), logic'(i >> 1), logic'(i), 0, 0);
      #1;
      check_comb($sformatf("tt%0d", i));
      check($sformatf("tt%0d.s_tab", i),    32'(fa_if.s),    32'(s_tab[i]));
      check($sformatf("tt%0d.cout_tab", i), 32'(fa_if.cout), 32'(c_tab[i]));
    end
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Registered latency
    drive(1, 1, 1, 1, 0);
    tick();
    check_regs("lat_valid");
    check("lat_sq_one", 32'(fa_if.s_q), 32'(1));
    drive(0, 0, 0, 0, 0);
    tick();
    check_regs("lat_hold");
    check("lat_hold_cq", 32'(fa_if.cout_q), 32'(1));

    // Counter: 5 carries, 3 valid zeros, 2 invalid carries, interleaved
    drive(0, 0, 0, 0, 1);
    tick();
    for (int i = 0; i < 10; i++) begin
      case (i)
        0, 2, 5, 7, 9: drive(1, 1, logic'($urandom_range(1)), 1, 0);
        1, 4, 8:       drive(0, 0, 0, 1, 0);
        default:       drive(1, 1, 1, 0, 0);
      endcase
      tick();
      check_regs($sformatf("cnt%0d", i));
    end
    check("cnt_five", 32'(fa_if.carry_cnt), 32'(5));

    // Saturation on the 2-bit counter
    drive(0, 0, 0, 0, 1);
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, logic'($urandom_range(1)), 1, 0);
      tick();
      check_regs($sformatf("sat%0d", i));
    end
    check("sat_cnt2", 32'(d2_cnt), 32'(3));
    check("sat_flag", 32'(d2_sat), 32'(1));
    drive(1, 1, 1, 1, 1);
    tick();
    check_regs("clr_wins");
    check("clr_cnt2", 32'(d2_cnt), 32'(0));

    // Async reset mid-cycle with s_q=1 and carry_cnt=3
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 1, 0);
      tick();
    end
    check_regs("pre_rst");
    #2;
    rst = 1'b1;
    #1;
    m_sq = 0; m_coutq = 0; m_validq = 0; m_cnt8 = 0; m_cnt2 = 0;
    check_regs("async_rst");
    for (int i = 0; i < 4; i++) begin
      drive(logic'($urandom_range(1)), logic'($urandom_range(1)),
            logic'($urandom_range(1)), 1, 0);
      #0.5;
      check_comb($sformatf("rst_comb%0d", i));
    end
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1, 1, 1, 0);
    tick();
    check_regs("first_after_rst");

    // Randomized operation
    for (int i = 0; i < 150; i++) begin
      drive(logic'($urandom_range(1)), logic'($urandom_range(1)),
            logic'($urandom_range(1)), logic'($urandom_range(3) != 0),
            logic'($urandom_range(15) == 0));
      #1;
      check_comb($sformatf("rnd_comb%0d", i));
      tick();
      check_regs($sformatf("rnd%0d", i));
    end

    // Ripple chain
    ra = 4'hF; rb = 4'h0; rcin = 1'b1;
    #1;
    check("rip_F_0_c1.S",    32'(rs),    32'(4'h0));
    check("rip_F_0_c1.Cout", 32'(rc[4]), 32'(1));
    ra = 4'h7; rb = 4'h8; rcin = 1'b0;
    #1;
    check("rip_7_8_c0.S",    32'(rs),    32'(4'hF));
    check("rip_7_8_c0.Cout", 32'(rc[4]), 32'(0));
    for (int i = 0; i < 16; i++) begin
      ra = 4'($urandom); rb = 4'($urandom); rcin = 1'($urandom);
      #1;
      rip_exp = 5'(int'(ra) + int'(rb) + int'(rcin));
      check($sformatf("rip_rnd%0d", i), 32'({rc[4], rs}), 32'(rip_exp));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global timeout guard
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
